// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the alarm sequencer: state encoding and default timings.
package alarm_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int RING_SECS_DEF   = 60;
    localparam int SNOOZE_SECS_DEF = 300;
    localparam int MAX_SNOOZE_DEF  = 3;

endpackage

// File: rtl/alarm_sequencer.sv
// Buzzer/snooze sequencer sitting beside the alarm clock; runs on the 1 s tick.
//   state     | meaning
//   ST_IDLE   | waiting for a rising edge on alarm_in
//   ST_RING   | buzzer pulsing 1 s on / 1 s off, ring timer counting
//   ST_SNOOZE | silent, snooze timer counting down
//   ST_DONE   | stop_al held high until the alarm clock drops alarm_in
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int RING_SECS   = RING_SECS_DEF,
    parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
    input  logic       clk_1s,
    input  logic       reset,
    input  logic       alarm_in,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       stop_al,
    output logic       snoozing,
    output logic [1:0] snooze_left,
    output logic [1:0] state
);

    localparam logic [5:0] RING_LAST   = 6'(RING_SECS - 1);
    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS - 1);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_t     state_q;
    logic       alarm_dly_q;
    logic       buzzer_q;
    logic       stop_al_q;
    logic       snoozing_q;
    logic [1:0] snooze_left_q;
    logic [5:0] ring_cnt_q;
    logic [8:0] snooze_cnt_q;
    logic       trigger;

    assign trigger = alarm_in & ~alarm_dly_q;

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            alarm_dly_q   <= 1'b0;
            buzzer_q      <= 1'b0;
            stop_al_q     <= 1'b0;
            snoozing_q    <= 1'b0;
            snooze_left_q <= SNOOZE_MAX;
            ring_cnt_q    <= '0;
            snooze_cnt_q  <= '0;
        end else begin
            alarm_dly_q <= alarm_in;
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_q       <= ST_RING;
                        ring_cnt_q    <= '0;
                        buzzer_q      <= 1'b1;
                        snooze_left_q <= SNOOZE_MAX;
                    end else begin
                        buzzer_q <= 1'b0;
                    end
                end
                ST_RING: begin
                    // stop beats snooze beats timeout; an exhausted snooze just keeps ringing
                    if (stop_btn) begin
                        state_q   <= ST_DONE;
                        buzzer_q  <= 1'b0;
                        stop_al_q <= 1'b1;
                    end else if (snooze_btn && snooze_left_q != 2'd0) begin
                        state_q       <= ST_SNOOZE;
                        snooze_cnt_q  <= SNOOZE_LOAD;
                        snooze_left_q <= snooze_left_q - 2'd1;
                        buzzer_q      <= 1'b0;
                        snoozing_q    <= 1'b1;
                    end else if (ring_cnt_q == RING_LAST) begin
                        state_q   <= ST_DONE;
                        buzzer_q  <= 1'b0;
                        stop_al_q <= 1'b1;
                    end else begin
                        ring_cnt_q <= ring_cnt_q + 6'd1;
                        buzzer_q   <= ~buzzer_q;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_btn) begin
                        state_q    <= ST_DONE;
                        snoozing_q <= 1'b0;
                        stop_al_q  <= 1'b1;
                        buzzer_q   <= 1'b0;
                    end else if (snooze_cnt_q == 9'd0) begin
                        state_q    <= ST_RING;
                        ring_cnt_q <= '0;
                        buzzer_q   <= 1'b1;
                        snoozing_q <= 1'b0;
                    end else begin
                        snooze_cnt_q <= snooze_cnt_q - 9'd1;
                        buzzer_q     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    buzzer_q <= 1'b0;
                    if (!alarm_in) begin
                        state_q   <= ST_IDLE;
                        stop_al_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign buzzer      = buzzer_q;
    assign stop_al     = stop_al_q;
    assign snoozing    = snoozing_q;
    assign snooze_left = snooze_left_q;
    assign state       = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer at default timings (60 s ring, 300 s snooze, 3 snoozes).
module tb_alarm_sequencer;

    logic       clk_1s;
    logic       reset;
    logic       alarm_in;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer;
    logic       stop_al;
    logic       snoozing;
    logic [1:0] snooze_left;
    logic [1:0] state;

    int n_vec;
    int n_miss;

    alarm_sequencer dut (
        .clk_1s      (clk_1s),
        .reset       (reset),
        .alarm_in    (alarm_in),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .buzzer      (buzzer),
        .stop_al     (stop_al),
        .snoozing    (snoozing),
        .snooze_left (snooze_left),
        .state       (state)
    );

    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_1s);
            #1;
        end
    endtask

    task automatic snooze_cycle(input int exp_left);
        snooze_btn = 1'b1;
        tick(1);
        snooze_btn = 1'b0;
        chk_val("snz_state", int'(state), 2);
        chk_val("snz_left", int'(snooze_left), exp_left);
        chk_val("snz_buzz", int'(buzzer), 0);
        chk_val("snz_flag", int'(snoozing), 1);
        tick(299);
        chk_val("snz_299_state", int'(state), 2);
        chk_val("snz_299_buzz", int'(buzzer), 0);
        tick(1);
        chk_val("snz_300_state", int'(state), 1);
        chk_val("snz_300_buzz", int'(buzzer), 1);
        chk_val("snz_300_flag", int'(snoozing), 0);
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        reset      = 1'b1;
        alarm_in   = 1'b0;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        #2;
        chk_val("rst_state", int'(state), 0);
        chk_val("rst_buzz", int'(buzzer), 0);
        chk_val("rst_stop_al", int'(stop_al), 0);
        chk_val("rst_snoozing", int'(snoozing), 0);
        chk_val("rst_left", int'(snooze_left), 3);
        tick(2);
        reset = 1'b0;
        tick(2);
        chk_val("idle_state", int'(state), 0);

        // ring pattern and timeout
        alarm_in = 1'b1;
        tick(1);
        chk_val("ring_state", int'(state), 1);
        chk_val("ring_buzz0", int'(buzzer), 1);
        chk_val("ring_left", int'(snooze_left), 3);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk_val("ring_buzz_pat", int'(buzzer), (i % 2 == 0) ? 1 : 0);
        end
        tick(55);
        chk_val("ring59_state", int'(state), 1);
        chk_val("ring59_buzz", int'(buzzer), 0);
        tick(1);
        chk_val("tmo_state", int'(state), 3);
        chk_val("tmo_stop_al", int'(stop_al), 1);
        chk_val("tmo_buzz", int'(buzzer), 0);
        tick(1);
        chk_val("done_hold", int'(state), 3);
        alarm_in = 1'b0;
        tick(1);
        chk_val("done_idle", int'(state), 0);
        chk_val("done_stop_al", int'(stop_al), 0);

        // three snoozes, then snooze ignored, then stop
        alarm_in = 1'b1;
        tick(3);
        chk_val("r2_state", int'(state), 1);
        chk_val("r2_buzz", int'(buzzer), 1);
        snooze_cycle(2);
        snooze_cycle(1);
        snooze_cycle(0);
        snooze_btn = 1'b1;
        tick(1);
        chk_val("exh_state", int'(state), 1);
        chk_val("exh_buzz0", int'(buzzer), 0);
        chk_val("exh_left", int'(snooze_left), 0);
        tick(1);
        chk_val("exh_buzz1", int'(buzzer), 1);
        snooze_btn = 1'b0;
        stop_btn   = 1'b1;
        tick(1);
        stop_btn = 1'b0;
        chk_val("stop_state", int'(state), 3);
        chk_val("stop_buzz", int'(buzzer), 0);
        chk_val("stop_left", int'(snooze_left), 0);
        alarm_in = 1'b0;
        tick(1);
        chk_val("stop_idle", int'(state), 0);

        // simultaneous stop and snooze
        alarm_in = 1'b1;
        tick(1);
        chk_val("both_ring", int'(state), 1);
        chk_val("both_left0", int'(snooze_left), 3);
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        tick(1);
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        chk_val("both_state", int'(state), 3);
        chk_val("both_left", int'(snooze_left), 3);
        chk_val("both_snoozing", int'(snoozing), 0);
        alarm_in = 1'b0;
        tick(1);

        // stop during snooze
        alarm_in = 1'b1;
        tick(1);
        snooze_btn = 1'b1;
        tick(1);
        snooze_btn = 1'b0;
        tick(5);
        stop_btn = 1'b1;
        tick(1);
        stop_btn = 1'b0;
        chk_val("snzstop_state", int'(state), 3);
        chk_val("snzstop_flag", int'(snoozing), 0);
        chk_val("snzstop_stop_al", int'(stop_al), 1);
        alarm_in = 1'b0;
        tick(1);

        // async reset mid-snooze with alarm held high
        alarm_in = 1'b1;
        tick(1);
        snooze_btn = 1'b1;
        tick(1);
        snooze_btn = 1'b0;
        tick(10);
        chk_val("pre_rst_state", int'(state), 2);
        #2 reset = 1'b1;
        #1;
        chk_val("arst_state", int'(state), 0);
        chk_val("arst_snoozing", int'(snoozing), 0);
        chk_val("arst_left", int'(snooze_left), 3);
        chk_val("arst_buzz", int'(buzzer), 0);
        chk_val("arst_stop_al", int'(stop_al), 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk_val("post_rst_state", int'(state), 1);
        chk_val("post_rst_buzz", int'(buzzer), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
